// File: rtl/axis_conv_sequencer_if.sv
// Descriptor handshake plus conv control stream of axis_conv_sequencer.
// master = sequencer side, slave = descriptor source / beat consumer side.
interface axis_conv_sequencer_if #(
    parameter int BITS_KERNEL_H       = 2,
    parameter int BITS_KERNEL_W       = 2,
    parameter int BITS_CIN            = 10,
    parameter int BITS_COLS           = 9,
    parameter int BITS_BLOCKS         = 5,
    parameter int TUSER_WIDTH_CONV_IN = 9 + BITS_KERNEL_W
);
    // Both channels transfer on a rising edge with valid && ready; the source
    // keeps valid and payload stable until that edge, ready may change freely.
    logic                           s_cfg_valid;
    logic                           s_cfg_ready;
    logic [BITS_KERNEL_H-1:0]       s_cfg_kernel_h_1;
    logic [BITS_KERNEL_W-1:0]       s_cfg_kernel_w_1;
    logic [BITS_CIN-1:0]            s_cfg_cin_1;
    logic [BITS_COLS-1:0]           s_cfg_cols_1;
    logic [BITS_BLOCKS-1:0]         s_cfg_blocks_1;
    logic                           s_cfg_is_max;
    logic                           s_cfg_is_lrelu;
    logic                           m_axis_tvalid;
    logic                           m_axis_tready;
    logic                           m_axis_tlast;
    logic [TUSER_WIDTH_CONV_IN-1:0] m_axis_tuser;

    modport master (
        input  s_cfg_valid, s_cfg_kernel_h_1, s_cfg_kernel_w_1, s_cfg_cin_1,
               s_cfg_cols_1, s_cfg_blocks_1, s_cfg_is_max, s_cfg_is_lrelu,
               m_axis_tready,
        output s_cfg_ready, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        output s_cfg_valid, s_cfg_kernel_h_1, s_cfg_kernel_w_1, s_cfg_cin_1,
               s_cfg_cols_1, s_cfg_blocks_1, s_cfg_is_max, s_cfg_is_lrelu,
               m_axis_tready,
        input  s_cfg_ready, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/axis_conv_sequencer.sv
// Layer scheduler for the conv input pipe: one control beat per conv step over blocks x cin x cols.
// Optional back-pressure counter enabled by defining CONV_SEQ_STALL_COUNT_EN.
module axis_conv_sequencer #(
    parameter int KERNEL_H_MAX        = 3,
    parameter int KERNEL_W_MAX        = 3,
    parameter int IM_CIN_MAX          = 1024,
    parameter int IM_COLS_MAX         = 384,
    parameter int IM_BLOCKS_MAX       = 32,
    parameter int BEATS_CONFIG_3X3_1  = 20,
    parameter int BEATS_CONFIG_1X1_1  = 12,
    parameter int BITS_KERNEL_H       = $clog2(KERNEL_H_MAX),
    parameter int BITS_KERNEL_W       = $clog2(KERNEL_W_MAX),
    parameter int BITS_CIN            = $clog2(IM_CIN_MAX),
    parameter int BITS_COLS           = $clog2(IM_COLS_MAX),
    parameter int BITS_BLOCKS         = $clog2(IM_BLOCKS_MAX),
    parameter int TUSER_WIDTH_CONV_IN = 9 + BITS_KERNEL_W
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    axis_conv_sequencer_if.master       bus,
    output logic                        done,
    output logic [31:0]                 stall_count,
    output logic [1:0]                  dbg_state
);
    localparam int CFG_MAX  = (BEATS_CONFIG_3X3_1 > BEATS_CONFIG_1X1_1) ?
                              BEATS_CONFIG_3X3_1 : BEATS_CONFIG_1X1_1;
    localparam int BITS_CFG = $clog2(CFG_MAX + 1);
    localparam logic [BITS_CFG-1:0] CFG_LIM_3X3 = BITS_CFG'(BEATS_CONFIG_3X3_1);
    localparam logic [BITS_CFG-1:0] CFG_LIM_1X1 = BITS_CFG'(BEATS_CONFIG_1X1_1);

    typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_RUN, S_DONE} state_e;

    state_e                         state_q;
    logic [BITS_KERNEL_H-1:0]       kh_q;
    logic [BITS_KERNEL_W-1:0]       kw_q;
    logic [BITS_CIN-1:0]            cin_1_q, cin_q;
    logic [BITS_COLS-1:0]           cols_1_q, col_q;
    logic [BITS_BLOCKS-1:0]         blocks_1_q, blk_q;
    logic                           is_max_q, is_lrelu_q;
    logic [BITS_CFG-1:0]            cfg_lim_q, cfg_cnt_q;
    logic                           ready_q, tvalid_q, tlast_q, done_q;
    logic [TUSER_WIDTH_CONV_IN-1:0] tuser_q;

    logic                           beat_fire, accept;
    logic [BITS_COLS-1:0]           col_d;
    logic [BITS_CIN-1:0]            cin_d;
    logic [BITS_BLOCKS-1:0]         blk_d;

    assign beat_fire = tvalid_q && bus.m_axis_tready;
    assign accept    = (state_q == S_IDLE) && ready_q && bus.s_cfg_valid;
    assign col_d     = col_q + BITS_COLS'(1);
    assign cin_d     = cin_q + BITS_CIN'(1);
    assign blk_d     = blk_q + BITS_BLOCKS'(1);

    // Column flag compares against cols_1 - kw/2 in one extra signed bit so
    // narrow images with a wide kernel never raise it.
    function automatic logic [TUSER_WIDTH_CONV_IN-1:0] conv_word(
        input logic                     is_cfg,
        input logic                     is_max,
        input logic                     is_lrelu,
        input logic [BITS_KERNEL_H-1:0] kh,
        input logic [BITS_KERNEL_W-1:0] kw,
        input logic [BITS_COLS-1:0]     cols_1,
        input logic [BITS_COLS-1:0]     col,
        input logic                     acc_last,
        input logic                     top,
        input logic                     bottom
    );
        logic signed [BITS_COLS:0]      k2_pos;
        logic [TUSER_WIDTH_CONV_IN-1:0] w;
        k2_pos = $signed({1'b0, cols_1}) -
                 $signed({{(BITS_COLS + 1 - BITS_KERNEL_W){1'b0}}, kw >> 1});
        w                   = '0;
        w[0]                = !is_max;
        w[1]                = is_max;
        w[2]                = is_lrelu;
        w[3]                = top;
        w[4]                = bottom;
        w[5]                = (kh == '0);
        w[6]                = !is_cfg && !k2_pos[BITS_COLS] && (k2_pos[BITS_COLS-1:0] == col);
        w[7]                = is_cfg;
        w[8]                = !is_cfg && acc_last;
        w[9 +: BITS_KERNEL_W] = kw;
        return w;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            kh_q       <= '0;
            kw_q       <= '0;
            cin_1_q    <= '0;
            cols_1_q   <= '0;
            blocks_1_q <= '0;
            is_max_q   <= 1'b0;
            is_lrelu_q <= 1'b0;
            cfg_lim_q  <= '0;
            cfg_cnt_q  <= '0;
            col_q      <= '0;
            cin_q      <= '0;
            blk_q      <= '0;
            ready_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        kh_q       <= bus.s_cfg_kernel_h_1;
                        kw_q       <= bus.s_cfg_kernel_w_1;
                        cin_1_q    <= bus.s_cfg_cin_1;
                        cols_1_q   <= bus.s_cfg_cols_1;
                        blocks_1_q <= bus.s_cfg_blocks_1;
                        is_max_q   <= bus.s_cfg_is_max;
                        is_lrelu_q <= bus.s_cfg_is_lrelu;
                        cfg_lim_q  <= (bus.s_cfg_kernel_h_1 == '0) ? CFG_LIM_1X1 : CFG_LIM_3X3;
                        cfg_cnt_q  <= '0;
                        col_q      <= '0;
                        cin_q      <= '0;
                        blk_q      <= '0;
                        ready_q    <= 1'b0;
                        tvalid_q   <= 1'b1;
                        tlast_q    <= 1'b0;
                        tuser_q    <= conv_word(1'b1, bus.s_cfg_is_max, bus.s_cfg_is_lrelu,
                                                bus.s_cfg_kernel_h_1, bus.s_cfg_kernel_w_1,
                                                bus.s_cfg_cols_1, '0, 1'b0, 1'b1,
                                                bus.s_cfg_blocks_1 == '0);
                        state_q    <= S_CONFIG;
                    end
                end
                S_CONFIG: begin
                    if (beat_fire) begin
                        if (cfg_cnt_q == cfg_lim_q) begin
                            cfg_cnt_q <= '0;
                            col_q     <= '0;
                            cin_q     <= '0;
                            tlast_q   <= (cols_1_q == '0) && (cin_1_q == '0);
                            tuser_q   <= conv_word(1'b0, is_max_q, is_lrelu_q, kh_q, kw_q,
                                                   cols_1_q, '0, cin_1_q == '0,
                                                   blk_q == '0, blk_q == blocks_1_q);
                            state_q   <= S_RUN;
                        end else begin
                            cfg_cnt_q <= cfg_cnt_q + BITS_CFG'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (beat_fire) begin
                        if (col_q != cols_1_q) begin
                            col_q   <= col_d;
                            tlast_q <= (col_d == cols_1_q) && (cin_q == cin_1_q);
                            tuser_q <= conv_word(1'b0, is_max_q, is_lrelu_q, kh_q, kw_q,
                                                 cols_1_q, col_d, cin_q == cin_1_q,
                                                 blk_q == '0, blk_q == blocks_1_q);
                        end else if (cin_q != cin_1_q) begin
                            col_q   <= '0;
                            cin_q   <= cin_d;
                            tlast_q <= (cols_1_q == '0) && (cin_d == cin_1_q);
                            tuser_q <= conv_word(1'b0, is_max_q, is_lrelu_q, kh_q, kw_q,
                                                 cols_1_q, '0, cin_d == cin_1_q,
                                                 blk_q == '0, blk_q == blocks_1_q);
                        end else if (blk_q != blocks_1_q) begin
                            col_q     <= '0;
                            cin_q     <= '0;
                            blk_q     <= blk_d;
                            cfg_cnt_q <= '0;
                            tlast_q   <= 1'b0;
                            tuser_q   <= conv_word(1'b1, is_max_q, is_lrelu_q, kh_q, kw_q,
                                                   cols_1_q, '0, 1'b0, 1'b0,
                                                   blk_d == blocks_1_q);
                            state_q   <= S_CONFIG;
                        end else begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            tuser_q  <= '0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef CONV_SEQ_STALL_COUNT_EN
    logic [31:0] stall_q;

    // Holds after done so the layer's figure can be read until the next accept.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (tvalid_q && !bus.m_axis_tready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

    assign bus.s_cfg_ready   = ready_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.m_axis_tuser  = tuser_q;
    assign done              = done_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_axis_conv_sequencer.sv
// Self-checking bench for axis_conv_sequencer: descriptor driver, tready driver,
// scoreboard of expected beats and a final report.
`timescale 1ns/1ps
module tb_axis_conv_sequencer;
    localparam int BKH = 2;
    localparam int BKW = 2;
    localparam int BCI = 10;
    localparam int BCO = 9;
    localparam int BBL = 5;
    localparam int TW  = 9 + BKW;
    localparam int EW  = TW + 2;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        done;
    logic [31:0] stall_count;
    logic [1:0]  dbg_state;

    axis_conv_sequencer_if #(
        .BITS_KERNEL_H(BKH), .BITS_KERNEL_W(BKW), .BITS_CIN(BCI),
        .BITS_COLS(BCO), .BITS_BLOCKS(BBL), .TUSER_WIDTH_CONV_IN(TW)
    ) bus ();

    axis_conv_sequencer dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus),
        .done(done),
        .stall_count(stall_count),
        .dbg_state(dbg_state)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];
    int layers_acc = 0;
    int layers_done = 0;
    int stall_total = 0;
    int stall_base = 0;
    int cur_beats = 0, cur_tlast = 0, cur_k2 = 0;
    int last_beats = 0, last_tlast = 0, last_k2 = 0;
    bit done_exp = 0;
    bit hold_pend = 0;
    logic [TW-1:0] held;
    bit rand_ready = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference beat sequence for one layer, in emission order.
    task automatic push_layer(input int kh, input int kw, input int cin_1, input int cols_1,
                              input int blocks_1, input bit is_max, input bit is_lrelu);
        int lim, k2col;
        logic [TW-1:0] w;
        bit last, fin;
        lim   = (kh == 0) ? 12 : 20;
        k2col = cols_1 - (kw / 2);
        for (int b = 0; b <= blocks_1; b++) begin
            for (int c = 0; c <= lim; c++) begin
                w = '0;
                w[0] = !is_max; w[1] = is_max; w[2] = is_lrelu;
                w[3] = (b == 0); w[4] = (b == blocks_1); w[5] = (kh == 0);
                w[7] = 1'b1; w[9 +: BKW] = kw[BKW-1:0];
                exp_q.push_back({1'b0, 1'b0, w});
            end
            for (int ci = 0; ci <= cin_1; ci++) begin
                for (int co = 0; co <= cols_1; co++) begin
                    w = '0;
                    w[0] = !is_max; w[1] = is_max; w[2] = is_lrelu;
                    w[3] = (b == 0); w[4] = (b == blocks_1); w[5] = (kh == 0);
                    w[6] = (co == k2col); w[8] = (ci == cin_1); w[9 +: BKW] = kw[BKW-1:0];
                    last = (co == cols_1) && (ci == cin_1);
                    fin  = last && (b == blocks_1);
                    exp_q.push_back({fin, last, w});
                end
            end
        end
    endtask

    always @(negedge aclk) begin : monitor
        logic [EW-1:0] e;
        if (!aresetn) begin
            exp_q.delete();
            done_exp = 0; hold_pend = 0;
            cur_beats = 0; cur_tlast = 0; cur_k2 = 0;
        end else begin
            check_eq("done", done, done_exp);
            if (done) layers_done++;
            if (hold_pend) check_eq("hold_tuser", bus.m_axis_tuser, held);
            if (bus.m_axis_tvalid) check_eq("busy_rdy", bus.s_cfg_ready, 0);
            done_exp = 0;
            hold_pend = 0;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                check_eq("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("tuser", bus.m_axis_tuser, e[TW-1:0]);
                    check_eq("tlast", bus.m_axis_tlast, e[TW]);
                    cur_beats++;
                    if (bus.m_axis_tlast) cur_tlast++;
                    if (bus.m_axis_tuser[6]) cur_k2++;
                    if (e[TW+1]) begin
                        done_exp = 1;
                        last_beats = cur_beats; last_tlast = cur_tlast; last_k2 = cur_k2;
                        cur_beats = 0; cur_tlast = 0; cur_k2 = 0;
                    end
                end
            end else if (bus.m_axis_tvalid) begin
                hold_pend = 1;
                held = bus.m_axis_tuser;
                stall_total++;
            end
        end
    end

    initial begin : ready_driver
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            bus.m_axis_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic send_cfg(input int kh, input int kw, input int cin_1, input int cols_1,
                            input int blocks_1, input bit is_max, input bit is_lrelu);
        int budget;
        bit acc;
        budget = 3000;
        acc = 0;
        @(posedge aclk);
        #2;
        bus.s_cfg_valid      = 1'b1;
        bus.s_cfg_kernel_h_1 = kh[BKH-1:0];
        bus.s_cfg_kernel_w_1 = kw[BKW-1:0];
        bus.s_cfg_cin_1      = cin_1[BCI-1:0];
        bus.s_cfg_cols_1     = cols_1[BCO-1:0];
        bus.s_cfg_blocks_1   = blocks_1[BBL-1:0];
        bus.s_cfg_is_max     = is_max;
        bus.s_cfg_is_lrelu   = is_lrelu;
        while (!acc && budget > 0) begin
            @(negedge aclk);
            if (bus.s_cfg_ready) acc = 1;
            else budget--;
        end
        check_eq("cfg_accept", acc, 1);
        if (acc) begin
            check_eq("prev_done", layers_done, layers_acc);
            push_layer(kh, kw, cin_1, cols_1, blocks_1, is_max, is_lrelu);
            layers_acc++;
            stall_base = stall_total;
            @(posedge aclk);
            #1;
            check_eq("first_beat", bus.m_axis_tvalid, 1);
            check_eq("rdy_drop", bus.s_cfg_ready, 0);
        end
        bus.s_cfg_valid = 1'b0;
    endtask

    task automatic wait_layer(input int budget);
        int n;
        n = 0;
        while (layers_done < layers_acc && n < budget) begin
            @(negedge aclk);
            n++;
        end
        check_eq("layer_done", layers_done >= layers_acc, 1);
        @(negedge aclk);
`ifdef CONV_SEQ_STALL_COUNT_EN
        check_eq("stall_cnt", stall_count, 32'(stall_total - stall_base));
`else
        check_eq("stall_cnt", stall_count, 0);
`endif
    endtask

    initial begin : timeout
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        bus.s_cfg_valid = 1'b0;
        bus.s_cfg_kernel_h_1 = '0; bus.s_cfg_kernel_w_1 = '0;
        bus.s_cfg_cin_1 = '0; bus.s_cfg_cols_1 = '0; bus.s_cfg_blocks_1 = '0;
        bus.s_cfg_is_max = 1'b0; bus.s_cfg_is_lrelu = 1'b0;

        repeat (3) @(negedge aclk);
        check_eq("rst_ready", bus.s_cfg_ready, 0);
        check_eq("rst_tvalid", bus.m_axis_tvalid, 0);
        check_eq("rst_tlast", bus.m_axis_tlast, 0);
        check_eq("rst_tuser", bus.m_axis_tuser, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_stall", stall_count, 0);
        check_eq("rst_state", dbg_state, 0);
        @(posedge aclk); #3 aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check_eq("idle_ready", bus.s_cfg_ready, 1);

        send_cfg(0, 0, 1, 2, 0, 1'b0, 1'b1);
        wait_layer(200);
        check_eq("1x1_beats", last_beats, 19);
        check_eq("1x1_tlasts", last_tlast, 1);

        send_cfg(2, 2, 0, 3, 1, 1'b1, 1'b0);
        wait_layer(300);
        check_eq("3x3_beats", last_beats, 50);
        check_eq("3x3_tlasts", last_tlast, 2);
        check_eq("3x3_k2", last_k2, 2);

        rand_ready = 1;
        send_cfg(2, 2, 0, 3, 1, 1'b1, 1'b0);
        wait_layer(1000);
        check_eq("rnd_beats", last_beats, 50);
        check_eq("rnd_tlasts", last_tlast, 2);
        rand_ready = 0;

        // Second descriptor stays valid through the whole first layer.
        send_cfg(2, 0, 1, 1, 0, 1'b0, 1'b1);
        send_cfg(0, 2, 0, 1, 1, 1'b1, 1'b1);
        wait_layer(300);
        check_eq("hold_beats", last_beats, 30);

        send_cfg(2, 2, 1, 3, 3, 1'b0, 1'b0);
        repeat (40) @(negedge aclk);
        @(posedge aclk); #3 aresetn = 1'b0;
        #1;
        check_eq("arst_tvalid", bus.m_axis_tvalid, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_state", dbg_state, 0);
        repeat (2) @(negedge aclk);
        layers_acc = layers_done;
        @(posedge aclk); #3 aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check_eq("arst_ready", bus.s_cfg_ready, 1);
        rand_ready = 1;
        send_cfg(0, 2, 2, 1, 2, 1'b1, 1'b1);
        wait_layer(1500);
        check_eq("post_rst_beats", last_beats, 57);
        check_eq("post_rst_tlasts", last_tlast, 3);
        rand_ready = 0;

        send_cfg(2, 2, 3, 0, 0, 1'b0, 1'b0);
        wait_layer(300);
        check_eq("narrow_beats", last_beats, 25);
        check_eq("narrow_k2", last_k2, 0);
        check_eq("narrow_tlasts", last_tlast, 1);

        for (int i = 0; i < 4; i++) begin
            rand_ready = ($urandom_range(0, 1) == 1);
            send_cfg($urandom_range(0, 1) * 2, $urandom_range(0, 1) * 2,
                     $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_layer(3000);
        end
        rand_ready = 0;

        repeat (3) @(negedge aclk);
        check_eq("queue_empty", exp_q.size(), 0);
        check_eq("end_ready", bus.s_cfg_ready, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
